wb_master_seq: RTL
==================

Name: wb_master_seq

Overview:
- Parametrised Wishbone master sequencer for the SD host controller bench and bring-up path.
- Replaces fixed-timing stimulus generators with a handshake-driven engine that replays a loaded list of register, FIFO and exec transactions.
- Honours ack_i and error_i, and waits for cmd_done_i / data_done_i after exec writes.
- Captures read data and reports completion, errors and timeouts.

Parameters:
- DATA_W, 128, Wishbone data width.
- ADR_W, 5, Wishbone address width.
- DEPTH, 16, number of transaction-list entries (power of 2, at least 2).
- TIMEOUT, 255, maximum wait cycles for ack or done before a timeout error.
- CMD_EXEC_ADR, 16, address whose write must be followed by cmd_done_i.
- DATA_EXEC_ADR, 19, address whose write must be followed by data_done_i.

Ports:
- wb_clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  empties the list; honoured in IDLE only.
- load_en  in  1  appends one entry; honoured in IDLE only.
- load_we  in  1  entry write-enable bit.
- load_adr  in  ADR_W  entry address.
- load_data  in  DATA_W  entry write data.
- start  in  1  pulse; starts list execution from entry 0.
- ack_i  in  1  slave acknowledge.
- error_i  in  1  slave error.
- wb_data_i  in  DATA_W  slave read data.
- cmd_done_i  in  1  command-complete indication.
- data_done_i  in  1  data-complete indication.
- we_o  out  1  write enable.
- adr_o  out  ADR_W  address.
- strobe_o  out  1  strobe.
- cyc_o  out  1  bus cycle.
- wb_data_o  out  DATA_W  write data.
- rd_data_o  out  DATA_W  captured read data.
- rd_valid_o  out  1  one-cycle pulse when rd_data_o updates.
- busy_o  out  1  high when the FSM is not in IDLE.
- done_o  out  1  one-cycle pulse at end of list.
- err_o  out  1  sticky error flag.
- timeout_o  out  1  sticky flag; error was a timeout.
- err_index_o  out  clog2(DEPTH)  index of the failing entry.
- count_o  out  clog2(DEPTH)+1  number of loaded entries.

Behaviour:
- Reset (reset=0, asynchronous): every output is 0, the list is empty (count 0), FSM goes to IDLE. List memory contents are don't-care.
- Loading:
  - load_en in IDLE writes {load_we, load_adr, load_data} at index count, then count increments.
  - When count==DEPTH, load_en is ignored and the list is unchanged.
  - load_en and clear are ignored outside IDLE.
  - clear sets count to 0. If clear and load_en are both high, clear wins.
- start in IDLE: clears err_o and timeout_o, sets idx=0, goes to ISSUE. If count==0, done_o pulses on the next cycle and the FSM stays in IDLE. start outside IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
- ISSUE (1 cycle): drive the entry onto we_o, adr_o, wb_data_o (wb_data_o=0 for reads), set cyc_o=strobe_o=1, clear the timer, go to WAIT_ACK.
- WAIT_ACK: outputs are held stable. Each cycle the timer increments.
  - ack_i: drop strobe_o and cyc_o next cycle. On a read, latch wb_data_i into rd_data_o and pulse rd_valid_o.
  - After ack_i on a write to CMD_EXEC_ADR or DATA_EXEC_ADR, go to WAIT_DONE. Otherwise go to NEXT.
  - error_i: takes priority over a simultaneous ack_i. It is an error.
  - Timer reaching TIMEOUT with no ack: error, and timeout_o=1.
- WAIT_DONE: waits for the matching done input (cmd_done_i or data_done_i), sampled as a level.
  - Done high, go to NEXT. Done already high on entry is accepted on the first cycle.
  - The timer restarts on entry; reaching TIMEOUT is a timeout error.
- NEXT: if idx==count-1, go to FINISH. Otherwise idx+1, go to ISSUE. The bus is always idle for at least one cycle between transactions.
- FINISH: pulse done_o, go to IDLE. The list is retained, so a new start replays it.
- Error handling: drop cyc_o and strobe_o, set err_o=1, err_index_o=idx, go to FINISH. done_o still pulses.
- Reset mid-transaction: bus outputs drop to 0 immediately (asynchronous).

Optional Feature:
- Macro WB_MASTER_SEQ_RETRY_EN.
- With the macro: on error_i or timeout, the same entry is reissued via ISSUE up to 3 times. The retry counter clears per entry. err_o is set only when the fourth attempt fails.
- Without the macro: the first error aborts, as specified above.

Test Plan:
- Load 3 entries {W,17,0x5}, {R,18}, {W,3,0xA}, start; ack each after 2 cycles -> 3 strobes; rd_data_o = wb_data_i from the 2nd; done_o pulses; err_o=0.
- Load {W,16,0x1}, ack; hold cmd_done_i low 10 cycles then high -> FSM stays in WAIT_DONE 10 cycles, then done_o pulses.
- Load 2 entries, error_i on entry 1 -> err_o=1, err_index_o=1, done_o pulses. With the macro: error on the first attempt only -> err_o=0.
- TIMEOUT=8, never ack -> strobe_o low after 8 wait cycles; err_o=1; timeout_o=1.
- Load DEPTH+1 entries -> count_o=DEPTH; the extra load is ignored. clear -> count_o=0. start -> done_o next cycle.
- Assert reset mid-WAIT_ACK -> cyc_o, strobe_o, busy_o are 0 immediately; count_o=0.

Source files
------------

// File: rtl/wb_master_seq.sv
// Wishbone master sequencer: replays a loaded list of register, FIFO and exec transactions with ack/error/done handshakes.
// Optional macro WB_MASTER_SEQ_RETRY_EN reissues a failing entry up to 3 times before flagging an error.
module wb_master_seq #(
  parameter int DATA_W        = 128,
  parameter int ADR_W         = 5,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT       = 255,
  parameter int CMD_EXEC_ADR  = 16,
  parameter int DATA_EXEC_ADR = 19
) (
  input  logic                     wb_clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load_en,
  input  logic                     load_we,
  input  logic [ADR_W-1:0]         load_adr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     start,
  input  logic                     ack_i,
  input  logic                     error_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  input  logic                     cmd_done_i,
  input  logic                     data_done_i,
  output logic                     we_o,
  output logic [ADR_W-1:0]         adr_o,
  output logic                     strobe_o,
  output logic                     cyc_o,
  output logic [DATA_W-1:0]        wb_data_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     timeout_o,
  output logic [$clog2(DEPTH)-1:0] err_index_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADR_W-1:0] CMD_A    = ADR_W'(CMD_EXEC_ADR);
  localparam logic [ADR_W-1:0] DATA_A   = ADR_W'(DATA_EXEC_ADR);
  localparam logic [TW-1:0]    TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0]    FULL     = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       count_q;
  logic [IW-1:0]       idx_q;
  logic [TW-1:0]       timer_q;
  logic                wait_exec_q;
  logic                wait_cmd_q;
  logic                we_q;
  logic [ADR_W-1:0]    adr_q;
  logic                stb_q;
  logic                cyc_q;
  logic [DATA_W-1:0]   wdat_q;
  logic [DATA_W-1:0]   rdat_q;
  logic                rvld_q;
  logic                done_q;
  logic                err_q;
  logic                tmo_q;
  logic [IW-1:0]       eidx_q;
`ifdef WB_MASTER_SEQ_RETRY_EN
  logic [1:0]          retry_q;
`endif

  logic                mem_we  [DEPTH];
  logic [ADR_W-1:0]    mem_adr [DEPTH];
  logic [DATA_W-1:0]   mem_dat [DEPTH];

  logic                load_ok_d;
  logic                done_lvl_d;
  logic                fail_d;
  logic                fail_tmo_d;
  logic                tmr_exp_d;
  logic [TW-1:0]       timer_d;
  logic                ent_we_d;
  logic [ADR_W-1:0]    ent_adr_d;

  assign load_ok_d  = (state_q == S_IDLE) && load_en && !clear && (count_q != FULL);
  assign done_lvl_d = wait_cmd_q ? cmd_done_i : data_done_i;
  assign tmr_exp_d  = (timer_q == TMR_LAST);
  assign timer_d    = timer_q + TW'(1);
  assign ent_we_d   = mem_we[idx_q];
  assign ent_adr_d  = mem_adr[idx_q];

  // An ack arriving on the last timer cycle still wins over the timeout.
  always_comb begin
    fail_d     = 1'b0;
    fail_tmo_d = 1'b0;
    if (state_q == S_WAIT_ACK) begin
      if (error_i) begin
        fail_d = 1'b1;
      end else if (!ack_i && tmr_exp_d) begin
        fail_d     = 1'b1;
        fail_tmo_d = 1'b1;
      end
    end else if (state_q == S_WAIT_DONE && !done_lvl_d && tmr_exp_d) begin
      fail_d     = 1'b1;
      fail_tmo_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clock) begin
    if (load_ok_d) begin
      mem_we[count_q[IW-1:0]]  <= load_we;
      mem_adr[count_q[IW-1:0]] <= load_adr;
      mem_dat[count_q[IW-1:0]] <= load_data;
    end
  end

  always_ff @(posedge wb_clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      wait_exec_q <= 1'b0;
      wait_cmd_q  <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
      wdat_q      <= '0;
      rdat_q      <= '0;
      rvld_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      eidx_q      <= '0;
`ifdef WB_MASTER_SEQ_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      rvld_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q == S_IDLE && clear) begin
        count_q <= '0;
      end else if (load_ok_d) begin
        count_q <= count_q + CW'(1);
      end

      if (fail_d) begin
        cyc_q <= 1'b0;
        stb_q <= 1'b0;
`ifdef WB_MASTER_SEQ_RETRY_EN
        if (retry_q != 2'd3) begin
          retry_q <= retry_q + 2'd1;
          state_q <= S_ISSUE;
        end else
`endif
        begin
          err_q   <= 1'b1;
          eidx_q  <= idx_q;
          state_q <= S_FINISH;
          if (fail_tmo_d) begin
            tmo_q <= 1'b1;
          end
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              err_q  <= 1'b0;
              tmo_q  <= 1'b0;
              eidx_q <= '0;
              idx_q  <= '0;
`ifdef WB_MASTER_SEQ_RETRY_EN
              retry_q <= '0;
`endif
              if (count_q == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            we_q        <= ent_we_d;
            adr_q       <= ent_adr_d;
            wdat_q      <= ent_we_d ? mem_dat[idx_q] : '0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            timer_q     <= '0;
            wait_exec_q <= ent_we_d && (ent_adr_d == CMD_A || ent_adr_d == DATA_A);
            wait_cmd_q  <= (ent_adr_d == CMD_A);
            state_q     <= S_WAIT_ACK;
          end
          S_WAIT_ACK: begin
            if (ack_i) begin
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              timer_q <= '0;
              if (!we_q) begin
                rdat_q <= wb_data_i;
                rvld_q <= 1'b1;
              end
              state_q <= wait_exec_q ? S_WAIT_DONE : S_NEXT;
            end else begin
              timer_q <= timer_d;
            end
          end
          S_WAIT_DONE: begin
            if (done_lvl_d) begin
              state_q <= S_NEXT;
            end else begin
              timer_q <= timer_d;
            end
          end
          S_NEXT: begin
            if ({1'b0, idx_q} == count_q - CW'(1)) begin
              state_q <= S_FINISH;
            end else begin
              idx_q   <= idx_q + IW'(1);
`ifdef WB_MASTER_SEQ_RETRY_EN
              retry_q <= '0;
`endif
              state_q <= S_ISSUE;
            end
          end
          S_FINISH: begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign strobe_o    = stb_q;
  assign cyc_o       = cyc_q;
  assign wb_data_o   = wdat_q;
  assign rd_data_o   = rdat_q;
  assign rd_valid_o  = rvld_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign timeout_o   = tmo_q;
  assign err_index_o = eidx_q;
  assign count_o     = count_q;

endmodule
